uart_tx_scheduler: RTL

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_tx_scheduler_if.sv | 30 +++
 rtl/uart_tx_scheduler.sv | 131 +++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler_if.sv
// rtl/uart_tx_scheduler_if.sv - CPU bus and uart_tx handshake bundle for uart_tx_scheduler
//
// Purpose: groups the CPU data-memory port and the uart_tx handshake.
// Ports:
//   bus_addr / bus_wrdata / bus_memwrite / bus_memread : CPU load/store port
//   bus_rddata                                         : status read data
//   stall                                              : CPU clock-freeze request
//   tx_data / tx_start / tx_ready                      : uart_tx transmit handshake
// Modports: master = CPU/uart_tx side, slave = scheduler side.
interface uart_tx_scheduler_if;
  logic [31:0] bus_addr;
  logic [31:0] bus_wrdata;
  logic        bus_memwrite;
  logic        bus_memread;
  logic [31:0] bus_rddata;
  logic        stall;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_ready;

  modport master (
    output bus_addr, bus_wrdata, bus_memwrite, bus_memread, tx_ready,
    input  bus_rddata, stall, tx_data, tx_start
  );

  modport slave (
    input  bus_addr, bus_wrdata, bus_memwrite, bus_memread, tx_ready,
    output bus_rddata, stall, tx_data, tx_start
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - byte FIFO between a CPU store port and uart_tx
//
// Purpose: CPU stores to DATA_ADDR queue a byte; the scheduler hands bytes
// to uart_tx one at a time in push order. A store to a full FIFO stalls the
// CPU until a slot frees. Loads from STATUS_ADDR return empty/full/busy/count.
// Ports:
//   clk  : single clock shared with uart_tx
//   rstn : asynchronous active-low reset
//   bus  : uart_tx_scheduler_if.slave (CPU bus + uart_tx handshake)
module uart_tx_scheduler #(
  parameter logic [31:0] DATA_ADDR   = 32'h2001,
  parameter logic [31:0] STATUS_ADDR = 32'h2002,
  parameter int          DEPTH       = 8
) (
  input logic               clk,
  input logic               rstn,
  uart_tx_scheduler_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;

  logic [7:0] fifo_mem [DEPTH];

  logic data_store;
  logic status_load;
  logic pop;
  logic push;
  logic empty;
  logic full;
  logic busy;
  logic unused_wrdata_hi;

  assign data_store  = bus.bus_memwrite && (bus.bus_addr == DATA_ADDR);
  assign status_load = bus.bus_memread && (bus.bus_addr == STATUS_ADDR);
  assign empty       = (count_q == '0);
  assign full        = (count_q == DEPTH_C);
  assign busy        = (state_q != IDLE);

  // A pop frees a slot in the same cycle, so a store to a full FIFO is
  // accepted on the very cycle the head leaves; an empty FIFO never pops.
  assign pop  = (state_q == IDLE) && !empty && bus.tx_ready;
  assign push = data_store && (!full || pop);

  assign bus.stall      = data_store && full && !pop;
  assign bus.bus_rddata = status_load ? {16'h0, 8'(count_q), 5'h0, busy, full, empty} : 32'h0;
  assign bus.tx_start   = tx_start_q;
  assign bus.tx_data    = tx_data_q;

  assign unused_wrdata_hi = ^bus.bus_wrdata[31:8];

  always_comb begin
    state_d    = state_q;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    unique case (state_q)
      IDLE: begin
        if (pop) begin
          tx_data_d  = fifo_mem[rd_ptr_q];
          tx_start_d = 1'b1;
          state_d    = START;
        end
      end
      // Request stays up until uart_tx shows it has taken the byte.
      START: begin
        if (!bus.tx_ready) begin
          tx_start_d = 1'b0;
          state_d    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (bus.tx_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        tx_start_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // Storage is left unreset; the pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= bus.bus_wrdata[7:0];
    end
  end

endmodule
